// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the retire-trace buffer: FSM state encodings and counter widths.
package wb_trace_buffer_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2
    } trace_state_e;

    // Width of the per-retire sequence number stored with every entry.
    localparam int unsigned SEQ_W = 16;

    // Width of the optional free-running cycle counter.
    localparam int unsigned TS_W = 32;

endpackage

// File: rtl/wb_trace_buffer_trace_fifo.sv
// trace_fifo: circular FIFO with show-ahead read, full/empty flags and registered occupancy.
// A push while full is ignored unless a pop happens in the same cycle.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr_q];

    // Pointer and occupancy state; flush empties the FIFO synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: retire-trace capture buffer behind the WB stage. Arm/trigger FSM,
// sequence counter, overflow tracking and a show-ahead drain port.
// Optional feature macro TRACE_TIMESTAMP_EN adds a 32-bit cycle counter, per-entry
// timestamp storage and the or_tstamp output.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int unsigned PC_W    = 24,
    parameter int unsigned INSTR_W = 24,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                       iw_clk,
    input  logic                       iw_rst_n,
    input  logic                       iw_wb_valid,
    input  logic [PC_W-1:0]            iw_wb_pc,
    input  logic [INSTR_W-1:0]         iw_wb_instr,
    input  logic [DATA_W-1:0]          iw_wb_result,
    input  logic                       iw_arm,
    input  logic                       iw_trig_en,
    input  logic [PC_W-1:0]            iw_trig_pc,
    input  logic                       iw_clear,
    input  logic                       iw_ready,
    output logic                       or_valid,
    output logic [PC_W-1:0]            or_pc,
    output logic [INSTR_W-1:0]         or_instr,
    output logic [DATA_W-1:0]          or_result,
    output logic [SEQ_W-1:0]           or_seq,
    output logic [$clog2(DEPTH):0]     or_count,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]            or_tstamp,
`endif
    output logic                       or_overflow,
    output logic [1:0]                 or_state
);

    localparam int unsigned BASE_W = PC_W + INSTR_W + DATA_W + SEQ_W;
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned ENTRY_W = BASE_W + TS_W;
`else
    localparam int unsigned ENTRY_W = BASE_W;
`endif
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    trace_state_e       state_q;
    trace_state_e       state_d;
    logic               capture;
    logic [SEQ_W-1:0]   seq_q;
    logic [SEQ_W-1:0]   seq_inc;
    logic               overflow_q;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               pop;

    // The stored sequence number includes the retire being recorded, so the first is 1.
    assign seq_inc = seq_q + SEQ_W'(1);
    assign pop     = !fifo_empty && iw_ready;

    // FSM state register.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and push request; clear overrides everything and discards a push.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (iw_arm) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (!iw_trig_en) begin
                    state_d = StCapture;
                end else if (iw_wb_valid && (iw_wb_pc == iw_trig_pc)) begin
                    // The matching instruction is the first one captured.
                    state_d = StCapture;
                    capture = 1'b1;
                end
            end
            StCapture: begin
                capture = iw_wb_valid;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (iw_clear) begin
            state_d = StIdle;
            capture = 1'b0;
        end
    end

    // Retire sequence counter: counts every retire regardless of FSM state.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            seq_q <= '0;
        end else if (iw_clear) begin
            seq_q <= '0;
        end else if (iw_wb_valid) begin
            seq_q <= seq_inc;
        end
    end

    // Sticky overflow: a capture was dropped because the FIFO was full and not draining.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            overflow_q <= 1'b0;
        end else if (iw_clear) begin
            overflow_q <= 1'b0;
        end else if (capture && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] cyc_q;

    // Free-running cycle counter, zeroed by clear.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            cyc_q <= '0;
        end else if (iw_clear) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + TS_W'(1);
        end
    end

    assign wr_entry = {cyc_q, seq_inc, iw_wb_result, iw_wb_instr, iw_wb_pc};
`else
    assign wr_entry = {seq_inc, iw_wb_result, iw_wb_instr, iw_wb_pc};
`endif

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (iw_clk),
        .rst_n   (iw_rst_n),
        .flush   (iw_clear),
        .push    (capture),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Head-entry fields, forced to zero while the FIFO is empty.
    always_comb begin
        or_pc     = '0;
        or_instr  = '0;
        or_result = '0;
        or_seq    = '0;
`ifdef TRACE_TIMESTAMP_EN
        or_tstamp = '0;
`endif
        if (!fifo_empty) begin
            or_pc     = rd_entry[0 +: PC_W];
            or_instr  = rd_entry[PC_W +: INSTR_W];
            or_result = rd_entry[PC_W + INSTR_W +: DATA_W];
            or_seq    = rd_entry[PC_W + INSTR_W + DATA_W +: SEQ_W];
`ifdef TRACE_TIMESTAMP_EN
            or_tstamp = rd_entry[BASE_W +: TS_W];
`endif
        end
    end

    assign or_valid    = !fifo_empty;
    assign or_count    = fifo_count;
    assign or_overflow = overflow_q;
    assign or_state    = state_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: table-driven vectors for the basic capture and
// trigger flows, hand-written sequences for overflow, full push+pop, clear and async reset.
`timescale 1ns/1ps
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [23:0] wb_pc = '0;
    logic [23:0] wb_instr = '0;
    logic [23:0] wb_result = '0;
    logic        arm = 1'b0;
    logic        trig_en = 1'b0;
    logic [23:0] trig_pc = '0;
    logic        clear = 1'b0;
    logic        ready = 1'b0;
    logic        o_valid;
    logic [23:0] o_pc;
    logic [23:0] o_instr;
    logic [23:0] o_result;
    logic [15:0] o_seq;
    logic [4:0]  o_count;
    logic        o_overflow;
    logic [1:0]  o_state;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] o_tstamp;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(
        .PC_W    (24),
        .INSTR_W (24),
        .DATA_W  (24),
        .DEPTH   (16)
    ) dut (
        .iw_clk       (clk),
        .iw_rst_n     (rst_n),
        .iw_wb_valid  (wb_valid),
        .iw_wb_pc     (wb_pc),
        .iw_wb_instr  (wb_instr),
        .iw_wb_result (wb_result),
        .iw_arm       (arm),
        .iw_trig_en   (trig_en),
        .iw_trig_pc   (trig_pc),
        .iw_clear     (clear),
        .iw_ready     (ready),
        .or_valid     (o_valid),
        .or_pc        (o_pc),
        .or_instr     (o_instr),
        .or_result    (o_result),
        .or_seq       (o_seq),
        .or_count     (o_count),
`ifdef TRACE_TIMESTAMP_EN
        .or_tstamp    (o_tstamp),
`endif
        .or_overflow  (o_overflow),
        .or_state     (o_state)
    );

    typedef struct {
        logic        arm;
        logic        trig_en;
        logic [23:0] trig_pc;
        logic        wb_valid;
        logic [23:0] wb_pc;
        logic        ready;
        logic        clear;
        logic        exp_valid;
        logic [23:0] exp_pc;
        logic [15:0] exp_seq;
        logic [4:0]  exp_count;
        logic [1:0]  exp_state;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [23:0] instr_of(input logic [23:0] pc);
        return pc ^ 24'hA5A000;
    endfunction

    function automatic logic [23:0] result_of(input logic [23:0] pc);
        return pc + 24'h000100;
    endfunction

    function automatic vec_t mk(input logic a, input logic te, input logic [23:0] tp,
                                input logic wv, input logic [23:0] wp, input logic rd,
                                input logic cl, input logic ev, input logic [23:0] ep,
                                input logic [15:0] es, input logic [4:0] ec,
                                input logic [1:0] est, input logic eo);
        vec_t v;
        v.arm = a; v.trig_en = te; v.trig_pc = tp; v.wb_valid = wv; v.wb_pc = wp;
        v.ready = rd; v.clear = cl; v.exp_valid = ev; v.exp_pc = ep; v.exp_seq = es;
        v.exp_count = ec; v.exp_state = est; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [23:0] pc);
        wb_valid  = v;
        wb_pc     = pc;
        wb_instr  = instr_of(pc);
        wb_result = result_of(pc);
    endtask

    task automatic chk_head(input string tag, input logic ev, input logic [23:0] ep,
                            input logic [15:0] es);
        chk({tag, "_valid"}, 32'(o_valid), 32'(ev));
        chk({tag, "_pc"}, 32'(o_pc), ev ? 32'(ep) : 32'd0);
        chk({tag, "_instr"}, 32'(o_instr), ev ? 32'(instr_of(ep)) : 32'd0);
        chk({tag, "_result"}, 32'(o_result), ev ? 32'(result_of(ep)) : 32'd0);
        chk({tag, "_seq"}, 32'(o_seq), ev ? 32'(es) : 32'd0);
    endtask

    task automatic retire(input logic [23:0] pc, input logic rd);
        set_wb(1'b1, pc);
        ready = rd;
        step();
        set_wb(1'b0, 24'h0);
        ready = 1'b0;
    endtask

    task automatic start_capture();
        clear = 1'b1;
        step();
        clear = 1'b0;
        arm = 1'b1;
        trig_en = 1'b0;
        step();
        arm = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        step();
        chk_head("rst", 1'b0, 24'h0, 16'h0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_state", 32'(o_state), 32'd0);
        rst_n = 1'b1;
        step();

        // Immediate capture, then trigger capture, then arm ignored in CAPTURE
        vecs.push_back(mk(1, 0, 24'h0, 0, 24'h0, 0, 0, 0, 24'h0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 24'h0, 0, 24'h0, 0, 0, 0, 24'h0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 24'h0, 1, 24'h10, 0, 0, 1, 24'h10, 1, 1, 2, 0));
        vecs.push_back(mk(0, 0, 24'h0, 1, 24'h11, 0, 0, 1, 24'h10, 1, 2, 2, 0));
        vecs.push_back(mk(0, 0, 24'h0, 1, 24'h12, 0, 0, 1, 24'h10, 1, 3, 2, 0));
        vecs.push_back(mk(0, 0, 24'h0, 1, 24'h13, 0, 0, 1, 24'h10, 1, 4, 2, 0));
        vecs.push_back(mk(0, 0, 24'h0, 0, 24'h0, 1, 0, 1, 24'h11, 2, 3, 2, 0));
        vecs.push_back(mk(0, 0, 24'h0, 0, 24'h0, 1, 0, 1, 24'h12, 3, 2, 2, 0));
        vecs.push_back(mk(0, 0, 24'h0, 0, 24'h0, 1, 0, 1, 24'h13, 4, 1, 2, 0));
        vecs.push_back(mk(0, 0, 24'h0, 0, 24'h0, 1, 0, 0, 24'h0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 24'h0, 0, 24'h0, 0, 1, 0, 24'h0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 24'h20, 0, 24'h0, 0, 0, 0, 24'h0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 24'h20, 1, 24'h1C, 0, 0, 0, 24'h0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 24'h20, 1, 24'h20, 0, 0, 1, 24'h20, 2, 1, 2, 0));
        vecs.push_back(mk(0, 1, 24'h20, 1, 24'h24, 0, 0, 1, 24'h20, 2, 2, 2, 0));
        vecs.push_back(mk(0, 1, 24'h20, 0, 24'h0, 1, 0, 1, 24'h24, 3, 1, 2, 0));
        vecs.push_back(mk(0, 1, 24'h20, 0, 24'h0, 1, 0, 0, 24'h0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 24'h20, 0, 24'h0, 0, 0, 0, 24'h0, 0, 0, 2, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            arm     = vecs[i].arm;
            trig_en = vecs[i].trig_en;
            trig_pc = vecs[i].trig_pc;
            ready   = vecs[i].ready;
            clear   = vecs[i].clear;
            set_wb(vecs[i].wb_valid, vecs[i].wb_pc);
            step();
            chk_head($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_seq);
            chk($sformatf("v%0d_count", i), 32'(o_count), 32'(vecs[i].exp_count));
            chk($sformatf("v%0d_state", i), 32'(o_state), 32'(vecs[i].exp_state));
            chk($sformatf("v%0d_ovf", i), 32'(o_overflow), 32'(vecs[i].exp_ovf));
        end
        arm = 1'b0; trig_en = 1'b0; ready = 1'b0; clear = 1'b0;
        set_wb(1'b0, 24'h0);

        // Overflow: 18 retires into a 16-deep FIFO with no draining
        start_capture();
        chk("ovf_state", 32'(o_state), 32'd2);
        for (int i = 0; i < 16; i++) retire(24'h100 + 24'(i), 1'b0);
        chk("ovf_full_count", 32'(o_count), 32'd16);
        chk("ovf_not_yet", 32'(o_overflow), 32'd0);
        retire(24'h110, 1'b0);
        chk("ovf_set", 32'(o_overflow), 32'd1);
        retire(24'h111, 1'b0);
        chk("ovf_count", 32'(o_count), 32'd16);
        chk("ovf_sticky", 32'(o_overflow), 32'd1);
        chk_head("ovf_head", 1'b1, 24'h100, 16'd1);

        // Full FIFO with simultaneous push and pop
        start_capture();
        chk("fp_ovf_cleared", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 16; i++) retire(24'h200 + 24'(i), 1'b0);
        chk("fp_count_full", 32'(o_count), 32'd16);
        retire(24'h300, 1'b1);
        chk("fp_count", 32'(o_count), 32'd16);
        chk("fp_ovf", 32'(o_overflow), 32'd0);
        chk_head("fp_head", 1'b1, 24'h201, 16'd2);
        ready = 1'b1;
        repeat (15) step();
        ready = 1'b0;
        chk("fp_tail_count", 32'(o_count), 32'd1);
        chk_head("fp_tail", 1'b1, 24'h300, 16'd17);

        // Clear coinciding with a retire in CAPTURE
        clear = 1'b1;
        set_wb(1'b1, 24'h400);
        step();
        clear = 1'b0;
        set_wb(1'b0, 24'h0);
        chk_head("clr", 1'b0, 24'h0, 16'h0);
        chk("clr_count", 32'(o_count), 32'd0);
        chk("clr_state", 32'(o_state), 32'd0);
        step();
        chk("clr_count_hold", 32'(o_count), 32'd0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        retire(24'h500, 1'b0);
        chk_head("clr_seq_restart", 1'b1, 24'h500, 16'd1);

        // Asynchronous reset in the middle of a cycle while capturing
        retire(24'h504, 1'b0);
        chk("ar_pre_count", 32'(o_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_head("ar", 1'b0, 24'h0, 16'h0);
        chk("ar_count", 32'(o_count), 32'd0);
        chk("ar_state", 32'(o_state), 32'd0);
        chk("ar_ovf", 32'(o_overflow), 32'd0);
        step();
        rst_n = 1'b1;
        retire(24'h600, 1'b0);
        chk("ar_no_capture_count", 32'(o_count), 32'd0);
        chk("ar_no_capture_state", 32'(o_state), 32'd0);

`ifdef TRACE_TIMESTAMP_EN
        // Timestamps follow the cycle counter, which clear zeroes
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int c = 0; c < 10; c++) begin
            arm = (c == 0);
            set_wb((c == 5) || (c == 9), 24'h700 + 24'(c));
            step();
        end
        arm = 1'b0;
        set_wb(1'b0, 24'h0);
        chk("ts_first", o_tstamp, 32'd5);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("ts_second", o_tstamp, 32'd9);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
